branch_resolve_pc: RTL and testbench

- Consumer end of the branch comparator interface.
- Drives the comparator's unsigned-select, takes back its less/equal flags, and decodes the B-type funct3 into a taken/not-taken decision.
- Owns the fetch PC register and redirects fetch on taken branches and jumps.
- Issues a registered multi-cycle pipeline flush, traps on misaligned targets, and keeps branch statistics counters.
- Sits between the EX stage (comparator plus target adder) and IF.

---
 rtl/branch_resolve_pc.sv | 168 ++++++++++++++++
 tb/tb_branch_resolve_pc.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_pc.sv
// branch_resolve_pc: resolves EX-stage branches and jumps against the
// comparator flags, owns the fetch PC, and issues redirects, multi-cycle
// IF/ID flushes and misaligned-target traps. It also keeps counters of
// resolved and taken conditional branches.
module branch_resolve_pc #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int          FLUSH_CYCLES = 2,
  parameter int          CNT_W        = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_stall,
  input  logic             i_br_valid,
  input  logic             i_is_jump,
  input  logic [2:0]       i_funct3,
  input  logic             i_br_less,
  input  logic             i_br_equal,
  input  logic [31:0]      i_target,
  input  logic [31:0]      i_ex_pc,
  input  logic             i_trap_ack,
  input  logic             i_cnt_clr,
  output logic             o_br_un,
  output logic             o_taken,
  output logic [31:0]      o_pc,
  output logic             o_flush,
  output logic             o_trap,
  output logic [31:0]      o_trap_pc,
  output logic [CNT_W-1:0] o_br_cnt,
  output logic [CNT_W-1:0] o_taken_cnt
);

  typedef enum logic [1:0] {RUN, FLUSH, TRAP} state_t;

  // Flush counter preload: counts down to 0 while o_flush is high.
  localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             flush_q, flush_d;
  logic             trap_q, trap_d;
  logic [31:0]      trap_pc_q, trap_pc_d;
  logic [1:0]       fcnt_q, fcnt_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

  logic cond_taken;
  logic f3_legal;
  logic taken;
  logic misaligned;

  // Unsigned compare for BLTU/BGEU, which are the only funct3 with bit 1 set.
  assign o_br_un = i_funct3[1];

  // Decode funct3 against the comparator flags.
  always_comb begin
    cond_taken = 1'b0;
    f3_legal   = 1'b1;
    case (i_funct3)
      3'b000:         cond_taken = i_br_equal;
      3'b001:         cond_taken = !i_br_equal;
      3'b100, 3'b110: cond_taken = i_br_less;
      3'b101, 3'b111: cond_taken = !i_br_less;
      default: begin
        cond_taken = 1'b0;
        f3_legal   = 1'b0;
      end
    endcase
  end

  // Jumps are unconditional; nothing resolves outside RUN (wrong path / trap).
  assign taken      = (i_br_valid | i_is_jump) & (i_is_jump | cond_taken) & (state_q == RUN);
  assign misaligned = (i_target[1:0] != 2'b00);
  assign o_taken    = taken;

  // Next-state, PC and flush/trap control.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    flush_d   = flush_q;
    trap_d    = trap_q;
    trap_pc_d = trap_pc_q;
    fcnt_d    = fcnt_q;
    case (state_q)
      RUN: begin
        if (taken && misaligned) begin
          trap_d    = 1'b1;
          trap_pc_d = i_ex_pc;
          state_d   = TRAP;
        end else if (taken) begin
          pc_d    = i_target;
          flush_d = 1'b1;
          fcnt_d  = FLUSH_INIT;
          state_d = FLUSH;
        end else if (!i_stall) begin
          pc_d = pc_q + 32'd4;
        end
      end
      FLUSH: begin
        if (!i_stall) begin
          pc_d = pc_q + 32'd4;
        end
        if (fcnt_q == 2'd0) begin
          flush_d = 1'b0;
          state_d = RUN;
        end else begin
          fcnt_d = fcnt_q - 2'd1;
        end
      end
      TRAP: begin
        if (i_trap_ack) begin
          pc_d    = TRAP_VECTOR;
          trap_d  = 1'b0;
          flush_d = 1'b1;
          fcnt_d  = FLUSH_INIT;
          state_d = FLUSH;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Statistics: only branches resolved in RUN count; clear beats increment.
  always_comb begin
    br_cnt_d    = br_cnt_q;
    taken_cnt_d = taken_cnt_q;
    if (i_cnt_clr) begin
      br_cnt_d    = '0;
      taken_cnt_d = '0;
    end else if ((state_q == RUN) && i_br_valid && !i_is_jump && f3_legal) begin
      br_cnt_d = br_cnt_q + CNT_W'(1);
      if (taken) begin
        taken_cnt_d = taken_cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= RUN;
      pc_q        <= RESET_VECTOR;
      flush_q     <= 1'b0;
      trap_q      <= 1'b0;
      trap_pc_q   <= 32'h0;
      fcnt_q      <= 2'd0;
      br_cnt_q    <= '0;
      taken_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      flush_q     <= flush_d;
      trap_q      <= trap_d;
      trap_pc_q   <= trap_pc_d;
      fcnt_q      <= fcnt_d;
      br_cnt_q    <= br_cnt_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign o_pc        = pc_q;
  assign o_flush     = flush_q;
  assign o_trap      = trap_q;
  assign o_trap_pc   = trap_pc_q;
  assign o_br_cnt    = br_cnt_q;
  assign o_taken_cnt = taken_cnt_q;

endmodule

// File: tb/tb_branch_resolve_pc.sv
// Scoreboard bench for branch_resolve_pc: the stimulus process pushes the
// hand-computed outputs expected in each cycle; a monitor pops and compares
// them on the falling edge.
module tb_branch_resolve_pc;

  logic        clk;
  logic        rst_n;
  logic        stall, br_valid, is_jump, br_less, br_equal, trap_ack, cnt_clr;
  logic [2:0]  funct3;
  logic [31:0] target, ex_pc;
  logic        br_un, taken, flush, trap;
  logic [31:0] pc, trap_pc, br_cnt, taken_cnt;

  branch_resolve_pc dut (
    .i_clk       (clk),
    .i_reset     (rst_n),
    .i_stall     (stall),
    .i_br_valid  (br_valid),
    .i_is_jump   (is_jump),
    .i_funct3    (funct3),
    .i_br_less   (br_less),
    .i_br_equal  (br_equal),
    .i_target    (target),
    .i_ex_pc     (ex_pc),
    .i_trap_ack  (trap_ack),
    .i_cnt_clr   (cnt_clr),
    .o_br_un     (br_un),
    .o_taken     (taken),
    .o_pc        (pc),
    .o_flush     (flush),
    .o_trap      (trap),
    .o_trap_pc   (trap_pc),
    .o_br_cnt    (br_cnt),
    .o_taken_cnt (taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        flush;
    logic        trap;
    logic [31:0] trap_pc;
    logic [31:0] br_cnt;
    logic [31:0] taken_cnt;
    logic        taken;
    logic        br_un;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Current expectation, edited by hand in the directed sequence.
  logic [31:0] e_pc, e_trap_pc, e_br_cnt, e_taken_cnt;
  logic        e_flush, e_trap, e_taken, e_br_un;

  task automatic chk(input string tag, input string fld, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%08h expected 0x%08h", tag, fld, act, req);
    end
  endtask

  // Monitor: one expected record per cycle, checked mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.tag, "pc",        pc,                 e.pc);
      chk(e.tag, "flush",     {31'b0, flush},     {31'b0, e.flush});
      chk(e.tag, "trap",      {31'b0, trap},      {31'b0, e.trap});
      chk(e.tag, "trap_pc",   trap_pc,            e.trap_pc);
      chk(e.tag, "br_cnt",    br_cnt,             e.br_cnt);
      chk(e.tag, "taken_cnt", taken_cnt,          e.taken_cnt);
      chk(e.tag, "taken",     {31'b0, taken},     {31'b0, e.taken});
      chk(e.tag, "br_un",     {31'b0, br_un},     {31'b0, e.br_un});
      $display("cycle %-12s pc=0x%08h flush=%0b trap=%0b trap_pc=0x%08h cnt=%0d/%0d taken=%0b br_un=%0b",
               e.tag, pc, flush, trap, trap_pc, br_cnt, taken_cnt, taken, br_un);
    end
  end

  // Push the expectation for the current cycle, then move to the next one.
  task automatic cyc(input string tag);
    exp_t e;
    e.tag = tag; e.pc = e_pc; e.flush = e_flush; e.trap = e_trap;
    e.trap_pc = e_trap_pc; e.br_cnt = e_br_cnt; e.taken_cnt = e_taken_cnt;
    e.taken = e_taken; e.br_un = e_br_un;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; br_valid = 0; is_jump = 0; funct3 = 3'b000; br_less = 0; br_equal = 0;
    target = 32'h0; ex_pc = 32'h0; trap_ack = 0; cnt_clr = 0;
    e_taken = 0; e_br_un = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    e_pc = 0; e_flush = 0; e_trap = 0; e_trap_pc = 0; e_br_cnt = 0; e_taken_cnt = 0;
    @(posedge clk);
    #1;
    cyc("reset");

    // Reset release, free-running fetch.
    rst_n = 1'b1;
    e_pc = 32'h0;  cyc("run0");
    e_pc = 32'h4;  cyc("run4");
    e_pc = 32'h8;  cyc("run8");
    e_pc = 32'hC;  cyc("runC");

    // BLTU 0xFFFFFFFF < 1 is false: not taken, counted.
    e_pc = 32'h10;
    br_valid = 1; funct3 = 3'b110; br_less = 0; target = 32'h80;
    e_br_un = 1; e_taken = 0;
    cyc("bltu_nt");
    idle_inputs();
    e_pc = 32'h14; e_br_cnt = 1; e_taken_cnt = 0;
    // Same cycle: BLT taken to 0x40 while stalled; redirect wins.
    br_valid = 1; funct3 = 3'b100; br_less = 1; target = 32'h40; stall = 1;
    e_taken = 1;
    cyc("blt_tk");
    idle_inputs();
    e_pc = 32'h40; e_flush = 1; e_br_cnt = 2; e_taken_cnt = 1;
    cyc("flush1");
    // Wrong-path taken BEQ during FLUSH: ignored.
    br_valid = 1; funct3 = 3'b000; br_equal = 1; target = 32'h80;
    e_pc = 32'h44; e_flush = 1; e_taken = 0;
    cyc("flush2_wp");
    idle_inputs();
    e_pc = 32'h48; e_flush = 0;
    cyc("post48");
    // Taken BEQ to misaligned 0x42 from EX pc 0x20.
    e_pc = 32'h4C;
    br_valid = 1; funct3 = 3'b000; br_equal = 1; target = 32'h42; ex_pc = 32'h20;
    e_taken = 1;
    cyc("beq_mis");
    idle_inputs();
    // In TRAP: EX inputs ignored, PC frozen.
    is_jump = 1; target = 32'h200;
    e_trap = 1; e_trap_pc = 32'h20; e_br_cnt = 3; e_taken_cnt = 2; e_taken = 0;
    for (int i = 0; i < 4; i++) cyc("trap_wait");
    trap_ack = 1;
    cyc("trap_ack");
    idle_inputs();
    e_pc = 32'h100; e_trap = 0; e_flush = 1;
    cyc("tvec0");
    e_pc = 32'h104; cyc("tvec4");
    e_pc = 32'h108; e_flush = 0; cyc("tvec8");
    // This cycle (pc 0x108) was idle; now BNE taken together with clear.
    e_pc = 32'h10C;
    br_valid = 1; funct3 = 3'b001; br_equal = 0; target = 32'h300; cnt_clr = 1;
    e_taken = 1;
    cyc("bne_clr");
    idle_inputs();
    e_pc = 32'h300; e_flush = 1; e_br_cnt = 0; e_taken_cnt = 0;
    cyc("clr_flush1");
    stall = 1;
    e_pc = 32'h304; cyc("clr_flush2");
    idle_inputs();
    // Stall held PC; flush finished. Illegal funct3 010 with both flags set.
    e_pc = 32'h304; e_flush = 0;
    br_valid = 1; funct3 = 3'b010; br_less = 1; br_equal = 1;
    e_br_un = 1; e_taken = 0;
    cyc("illegal");
    idle_inputs();
    // JAL to 0x500 with illegal funct3 encoding: taken, never counted.
    e_pc = 32'h308;
    is_jump = 1; funct3 = 3'b010; target = 32'h500;
    e_br_un = 1; e_taken = 1;
    cyc("jal");
    idle_inputs();
    e_pc = 32'h500; e_flush = 1;
    cyc("jal_flush1");
    // Asynchronous reset mid-flush: outputs drop before any clock edge.
    rst_n = 1'b0;
    e_pc = 32'h0; e_flush = 0; e_trap = 0; e_trap_pc = 0;
    cyc("async_rst");
    rst_n = 1'b1;
    e_pc = 32'h0; cyc("rel0");
    e_pc = 32'h4; cyc("rel4");

    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
